// File: rtl/console_paste_feeder.sv
// Queues host keyboard/paste bytes and feeds them one at a time to the PDP-8/I console
// transmitter, pacing characters so single-buffered console software keeps up.
module console_paste_feeder #(
  parameter int DEPTH        = 64,
  parameter int PACE_CYCLES  = 200000,
  parameter int CR_EXTRA     = 2000000,
  parameter bit LF_TO_CR     = 1'b1,
  parameter bit MARK_PARITY  = 1'b1,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [7:0]             out_data,
  output logic                   out_strobe,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);

  localparam int AW      = $clog2(DEPTH);
  localparam int GAP_MAX = PACE_CYCLES + CR_EXTRA;
  localparam int GW      = (GAP_MAX > 0) ? $clog2(GAP_MAX + 1) : 1;
  localparam int TW      = (BUSY_TIMEOUT > 0) ? $clog2(BUSY_TIMEOUT + 1) : 1;

  localparam logic [GW-1:0] GAP_NORM = GW'(PACE_CYCLES);
  localparam logic [GW-1:0] GAP_CR   = GW'(PACE_CYCLES + CR_EXTRA);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_IDLE, GAP} state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  state_t        state_q;
  logic [7:0]    out_data_q;
  logic          out_strobe_q;
  logic          is_cr_q;
  logic [GW-1:0] gap_q;
  logic [TW-1:0] tmo_q;

  logic          push, pop;
  logic [7:0]    head_xlat;
  logic [GW-1:0] gap_load;

  assign in_ready = (count_q != (AW+1)'(DEPTH)) & ~flush;
  assign push     = in_valid & in_ready;
  assign pop      = (state_q == IDLE) & (count_q != '0) & out_ready & ~flush;
  assign gap_load = is_cr_q ? GAP_CR : GAP_NORM;

  // LF->CR first, then mark parity, so a translated LF also gets bit 7 forced.
  always_comb begin
    head_xlat = mem_q[rd_ptr_q];
    if (LF_TO_CR && (head_xlat[6:0] == 7'h0A)) head_xlat[6:0] = 7'h0D;
    if (MARK_PARITY) head_xlat[7] = 1'b1;
  end

  // NOTE: the storage array has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      out_data_q   <= 8'h00;
      out_strobe_q <= 1'b0;
      is_cr_q      <= 1'b0;
      gap_q        <= '0;
      tmo_q        <= '0;
    end else begin
      out_strobe_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            out_data_q   <= head_xlat;
            out_strobe_q <= 1'b1;
            is_cr_q      <= (head_xlat[6:0] == 7'h0D);
            tmo_q        <= '0;
            state_q      <= WAIT_BUSY;
          end
        end
        // A transmitter that never drops ready must not hang the feeder.
        WAIT_BUSY: begin
          if (!out_ready || (tmo_q == TW'(BUSY_TIMEOUT - 1))) state_q <= WAIT_IDLE;
          else tmo_q <= tmo_q + TW'(1);
        end
        WAIT_IDLE: begin
          if (out_ready) begin
            gap_q   <= gap_load;
            state_q <= (gap_load == '0) ? IDLE : GAP;
          end
        end
        GAP: begin
          if (flush || (gap_q <= GW'(1))) begin
            gap_q   <= '0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_data   = out_data_q;
  assign out_strobe = out_strobe_q;
  assign count      = count_q;
  assign busy       = (state_q != IDLE) | (count_q != '0);

endmodule

// File: tb/tb_console_paste_feeder.sv
// Self-checking bench for console_paste_feeder: directed phases plus randomized rounds
// compared against a scoreboard of translated bytes and expected strobe spacing.
module tb_console_paste_feeder;

  localparam int DEPTH    = 4;
  localparam int PACE     = 10;
  localparam int CR_EXTRA = 30;
  localparam int TMO      = 4;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, flush, out_strobe, busy;
  logic       out_ready = 1'b1;
  logic [7:0] in_data, out_data;
  logic [2:0] count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic tx_hold     = 1'b0;
  int   tx_busy_len = 0;
  int   tx_cnt      = 0;

  int         strobe_cyc[$];
  logic [7:0] strobe_dat[$];
  logic [7:0] exp_q[$];
  int         viol        = 0;
  logic       prev_strobe = 1'b0;

  console_paste_feeder #(
    .DEPTH(DEPTH), .PACE_CYCLES(PACE), .CR_EXTRA(CR_EXTRA),
    .LF_TO_CR(1'b1), .MARK_PARITY(1'b1), .BUSY_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .out_data(out_data), .out_strobe(out_strobe), .out_ready(out_ready),
    .count(count), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter: busy for tx_busy_len cycles after each load (0 = never drops ready).
  always @(posedge clk) begin
    if (tx_hold) out_ready <= 1'b0;
    else if (out_strobe && out_ready && tx_busy_len > 0) begin
      tx_cnt    <= tx_busy_len;
      out_ready <= 1'b0;
    end else if (tx_cnt > 1) tx_cnt <= tx_cnt - 1;
    else begin
      tx_cnt    <= 0;
      out_ready <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (out_strobe) begin
      strobe_cyc.push_back(cyc);
      strobe_dat.push_back(out_data);
      if (!out_ready || prev_strobe) viol <= viol + 1;
    end
    prev_strobe <= out_strobe;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] xlat(input logic [7:0] b);
    int v = int'(b) % 128;
    if (v == 10) v = 13;
    return 8'(v + 128);
  endfunction

  function automatic int gap_after(input logic [7:0] sent);
    return PACE + ((int'(sent) % 128 == 13) ? CR_EXTRA : 0);
  endfunction

  // Strobe-to-strobe distance with the next byte already queued: transmitter busy
  // window (or the busy timeout), ready edge, gap, then pop and registered strobe.
  function automatic int spacing(input int b, input logic [7:0] sent);
    if (b == 0) return TMO + 2 + gap_after(sent);
    return b + 3 + gap_after(sent);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_sb();
    strobe_cyc.delete();
    strobe_dat.delete();
    exp_q.delete();
  endtask

  task automatic push_once(input logic [7:0] d, output bit took, output int pc);
    in_data  = d;
    in_valid = 1'b1;
    took     = in_ready;
    pc       = cyc;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (took) exp_q.push_back(xlat(d));
  endtask

  task automatic push_wait(input logic [7:0] d);
    bit took = 1'b0;
    int pc, k = 0;
    while (!took && k < 300) begin
      push_once(d, took, pc);
      k++;
    end
    if (!took) check("push_wait_timeout", 32'(took), 32'd1);
  endtask

  task automatic wait_strobes(input string tag, input int n, input int budget);
    int k = 0;
    while (strobe_cyc.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(strobe_cyc.size()), 32'(n));
  endtask

  task automatic wait_until_cyc(input int c);
    int k = 0;
    while (cyc < c && k < 1000) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || !out_ready) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_round(input string tag, input int b);
    for (int i = 0; i < exp_q.size() && i < strobe_dat.size(); i++) begin
      check({tag, "_data"}, 32'(strobe_dat[i]), 32'(exp_q[i]));
      if (i > 0)
        check({tag, "_spacing"}, 32'(strobe_cyc[i] - strobe_cyc[i-1]),
              32'(spacing(b, exp_q[i-1])));
    end
  endtask

  initial begin
    bit took;
    int pc, p0, s;
    logic [7:0] d;
    int n, b;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_strobe", 32'(out_strobe), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // First byte latency, pacing after a 5-cycle busy transmitter.
    tx_busy_len = 5;
    clear_sb();
    push_once(8'h41, took, p0);
    push_once(8'h42, took, pc);
    wait_strobes("pace_strobes", 2, 200);
    check("first_latency", 32'(strobe_cyc[0]), 32'(p0 + 2));
    check("pace_min", 32'(strobe_cyc[1] - strobe_cyc[0] >= 5 + PACE), 32'd1);
    check_round("pace", 5);
    s = strobe_cyc[1];
    wait_until_cyc(s + 16);
    check("busy_in_gap", 32'(busy), 32'd1);
    @(negedge clk);
    check("busy_after_gap", 32'(busy), 32'd0);

    // LF becomes marked CR and earns the longer gap.
    wait_idle();
    tx_busy_len = 0;
    clear_sb();
    push_once(8'h0A, took, pc);
    push_once(8'h41, took, pc);
    wait_strobes("lf_strobes", 2, 300);
    check("lf_to_cr", 32'(strobe_dat[0]), 32'h8D);
    check_round("lf", 0);

    // Fill to DEPTH, refuse the fifth byte, then drain with wrap-around.
    wait_idle();
    clear_sb();
    tx_hold = 1'b1;
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      push_once(8'h10 + 8'(i), took, pc);
      check("fill_took", 32'(took), 32'd1);
    end
    push_once(8'h14, took, pc);
    check("full_refused", 32'(took), 32'd0);
    check("full_count", 32'(count), 32'(DEPTH));
    tx_busy_len = 2;
    tx_hold = 1'b0;
    for (int i = 0; i < 6; i++) push_wait(8'h20 + 8'(i));
    wait_strobes("wrap_strobes", 10, 1000);
    check_round("wrap", 2);

    // Push and pop in the same cycle leave the occupancy unchanged.
    wait_idle();
    clear_sb();
    tx_hold = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) push_once(8'h30 + 8'(i), took, pc);
    tx_busy_len = 3;
    tx_hold = 1'b0;
    @(negedge clk);
    push_once(8'h33, took, pc);
    check("pushpop_took", 32'(took), 32'd1);
    check("pushpop_count", 32'(count), 32'd3);
    wait_strobes("pushpop_strobes", 4, 500);
    check_round("pushpop", 3);

    // Flush in the middle of a gap with three bytes still queued.
    wait_idle();
    clear_sb();
    tx_busy_len = 0;
    tx_hold = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_once(8'h50 + 8'(i), took, pc);
    tx_hold = 1'b0;
    wait_strobes("flush_first", 1, 50);
    s = strobe_cyc[0];
    check("flush_data", 32'(strobe_dat[0]), 32'(exp_q[0]));
    wait_until_cyc(s + 7);
    check("flush_pre_count", 32'(count), 32'd3);
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h77;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_idle", 32'(busy), 32'd0);
    repeat (60) @(negedge clk);
    check("flush_no_strobe", 32'(strobe_cyc.size()), 32'd1);

    // Reset while waiting for the transmitter to become idle again.
    wait_idle();
    clear_sb();
    tx_busy_len = 8;
    push_once(8'h61, took, pc);
    push_once(8'h62, took, pc);
    wait_strobes("rst_mid_first", 1, 50);
    s = strobe_cyc[0];
    wait_until_cyc(s + 4);
    check("rst_mid_busy", 32'(busy), 32'd1);
    check("rst_mid_out_data", 32'(out_data), 32'hE1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_strobe", 32'(out_strobe), 32'd0);
    check("rst_mid_data", 32'(out_data), 32'h00);
    check("rst_mid_busy0", 32'(busy), 32'd0);
    check("rst_mid_count", 32'(count), 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_mid_no_strobe", 32'(strobe_cyc.size()), 32'd1);

    // Transmitter that never drops ready: busy timeout, exactly one strobe per byte.
    wait_idle();
    clear_sb();
    tx_busy_len = 0;
    push_once(8'h71, took, pc);
    push_once(8'h0D, took, pc);
    push_once(8'h72, took, pc);
    wait_strobes("tmo_strobes", 3, 400);
    check_round("tmo", 0);
    repeat (80) @(negedge clk);
    check("tmo_no_double", 32'(strobe_cyc.size()), 32'd3);

    // Randomized rounds against the scoreboard.
    for (int r = 0; r < 8; r++) begin
      wait_idle();
      clear_sb();
      b = $urandom_range(0, 6);
      tx_busy_len = b;
      tx_hold = 1'b1;
      @(negedge clk);
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) d = ($urandom_range(0, 1) == 0) ? 8'h0A : 8'h8D;
        push_once(d, took, pc);
      end
      tx_hold = 1'b0;
      wait_strobes("rand_strobes", n, 600);
      check_round("rand", b);
    end

    repeat (5) @(negedge clk);
    check("protocol_violations", 32'(viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
